uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shared UART transmit controller: several on-chip requesters (debug monitor, CPU I/O port, status reporter, loopback echo) share one serial TX line. The block arbitrates round-robin between four byte requesters, latches the winning byte, and serialises it as an 8N1 frame on `portTX` at a fixed baud rate. It is the transmit-side companion of the UART receiver and uses the same baud convention, so the two pair on one serial port.

## Interface
- `BAUD_RATE`, 9650, line rate in bits/s.
- `CLKS_PER_BIT`, `50000000 / BAUD_RATE` (integer division), clocks per bit cell; derived, not overridden.
- `clk50Mhz`  in  1  50 MHz system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-low.
- `req`  in  4  per-requester transmit request; held high until granted.
- `reqData`  in  32  byte for requester i on `reqData[8*i+7:8*i]`; held stable while `req[i]` is high.
- `grant`  out  4  one-hot, single-cycle pulse: byte from requester i was accepted.
- `owner`  out  2  index of the requester whose frame is in progress; last winner while idle.
- `busy`  out  1  high from the accept edge through the end of the stop bit.
- `portTX`  out  1  serial line, registered, idle high.

## Operation
- States: IDLE, START, DATA, STOP.
- Reset (`reset`=0 at an edge) forces these register values: state IDLE, `portTX`=1, `grant`=0, `busy`=0, `owner`=3, round-robin pointer=3, bit timer=0, bit index=0.
- Reset mid-frame abandons the frame. `portTX` returns high on that edge. No grant is reissued, and requesters must keep `req` asserted to retry.
- IDLE, arbitration:
  - Searches `req` starting at (pointer+1) mod 4 and wrapping; the first set bit wins.
  - When a winner exists at an edge, on that edge: `grant[w]`=1, shift register loads `reqData` byte w, `owner`=w, pointer=w, `busy`=1, `portTX`=0, timer=0, next state START.
  - When `req`=0, the block stays in IDLE with `portTX`=1.
- START: `portTX`=0 for `CLKS_PER_BIT` clocks. At timer = `CLKS_PER_BIT`-1: timer resets to 0, `portTX` takes data bit 0, next state DATA.
- DATA: each bit is held `CLKS_PER_BIT` clocks, LSB first. A 3-bit index counts 0..7.
  - At the end of bit 7: `portTX`=1, next state STOP.
  - Otherwise the index increments and `portTX` takes the next bit.
- STOP: `portTX`=1 for `CLKS_PER_BIT` clocks. At the end of the stop bit: `busy`=0, next state IDLE.
- `grant` is high for exactly the accept cycle and low in all other cycles.
- `req` changes while busy have no effect on the frame in progress.
- A request dropped before its grant is never served, and no partial frame is sent.
- Timer is 16 bits, and `CLKS_PER_BIT` must be ≤ 65535; the bound holds for `BAUD_RATE` ≥ 763.
- Fairness: with all four requesting continuously, grants rotate 0,1,2,3,0,… A requester waits at most 3 frames.

## Timing
- Accept edge E: `grant` pulse, `busy` rises, `portTX` falls (start bit), all on the same edge.
- Start bit covers edges E..E+C-1, where C=`CLKS_PER_BIT`. Data bit k occupies E+C(k+1) .. E+C(k+2)-1. Stop bit occupies E+9C .. E+10C-1.
- `busy` falls and state returns to IDLE at edge E+10C.
- Earliest next accept is E+10C+1. Minimum frame-to-frame period is 10C+1 clocks, giving one idle-high clock between frames.
- `req[i]` seen high at edge k while IDLE gives `grant[i]` high during the cycle after edge k. Latency: 0 cycles of arbitration delay.
- All outputs are registered; no combinational path from `req` to `grant`/`portTX`.

## Test plan
- With `BAUD_RATE`=5000000 (C=10): reset low 3 cycles, then release. Required response: `portTX`=1, `busy`=0, `grant`=0, `owner`=3 throughout and after.
- `req`=4'b0001, byte0=8'hA5. Required response:
  - `grant`=0001 for 1 cycle.
  - `portTX` sequence is 0,1,0,1,0,0,1,0,1,1, each held 10 clocks.
  - `busy` high for exactly 100 clocks.
- `req`=4'b1111 held, bytes 8'h00/8'hFF/8'h55/8'h0F. Required response:
  - Grants in order 0001,0010,0100,1000,0001.
  - Grants spaced 101 clocks apart.
  - Each frame carries the matching byte.
- `req[2]` held, `req[1]` pulsed during frame 2's data bits, then dropped before STOP. Required response: no `grant[1]`, frame 2 unchanged, next grant to 2.
- Reset asserted at clock 45 of a frame. Required response: `portTX`=1 next edge, `busy`=0, no grant. After release with `req`=0001 held, a full new frame starts.
- After serving requester 3, assert `req`=4'b1001 simultaneously. Required response: `grant`=0001 (pointer wraps 3→0); the next grant goes to 3.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bundle of the shared UART transmitter: byte requests in, grant/status/serial line out.
interface uart_tx_arbiter_if;
    logic [3:0]  req;
    logic [31:0] reqData;
    logic [3:0]  grant;
    logic [1:0]  owner;
    logic        busy;
    logic        portTX;

    modport master (
        output req, reqData,
        input  grant, owner, busy, portTX
    );

    modport slave (
        input  req, reqData,
        output grant, owner, busy, portTX
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter over four byte requesters feeding one 8N1 serial transmitter.
// Grant on the same edge req is seen while idle; requesters hold req until granted, ignored while busy.
module uart_tx_arbiter #(
    parameter int BAUD_RATE = 9650
) (
    input  logic             clk50Mhz,
    input  logic             reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int          CLKS_PER_BIT = 50000000 / BAUD_RATE;
    localparam logic [15:0] C_LAST       = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      r_state;
    logic [15:0] r_timer;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic [1:0]  r_owner;
    logic [3:0]  r_grant;
    logic        r_busy;
    logic        r_tx;

    logic        w_found;
    logic [1:0]  w_win;
    logic        w_cell_end;

    // Scan downward so the requester right after the last winner is written last and wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_owner;
        for (int k = 4; k >= 1; k--) begin
            if (bus.req[r_owner + 2'(k)]) begin
                w_found = 1'b1;
                w_win   = r_owner + 2'(k);
            end
        end
    end

    assign w_cell_end = (r_timer == C_LAST);

    always_ff @(posedge clk50Mhz) begin
        if (!reset) begin
            r_state <= IDLE;
            r_tx    <= 1'b1;
            r_grant <= 4'b0000;
            r_busy  <= 1'b0;
            r_owner <= 2'd3;
            r_timer <= 16'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
        end else begin
            r_grant <= 4'b0000;
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (w_found) begin
                        r_grant <= 4'b0001 << w_win;
                        r_shift <= bus.reqData[{w_win, 3'b000} +: 8];
                        r_owner <= w_win;
                        r_busy  <= 1'b1;
                        r_tx    <= 1'b0;
                        r_timer <= 16'd0;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_cell_end) begin
                        r_timer <= 16'd0;
                        r_bit   <= 3'd0;
                        r_tx    <= r_shift[0];
                        r_state <= DATA;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                DATA: begin
                    if (w_cell_end) begin
                        r_timer <= 16'd0;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                            r_tx  <= r_shift[r_bit + 3'd1];
                        end
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                STOP: begin
                    if (w_cell_end) begin
                        r_timer <= 16'd0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.grant  = r_grant;
    assign bus.owner  = r_owner;
    assign bus.busy   = r_busy;
    assign bus.portTX = r_tx;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: expected (requester, byte) pairs queued as requests are driven, popped as frames appear.
module tb_uart_tx_arbiter;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #10 clk = ~clk;

    uart_tx_arbiter_if bus();

    uart_tx_arbiter #(.BAUD_RATE(5000000)) dut (
        .clk50Mhz (clk),
        .reset    (rst_n),
        .bus      (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc_cnt = 0;
    int last_grant_cyc = 0;
    int          exp_w_q[$];
    logic [7:0]  exp_b_q[$];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(int w, logic [7:0] b);
        exp_w_q.push_back(w);
        exp_b_q.push_back(b);
    endtask

    task automatic idle_check(string tag, int n);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_grant"},  bus.grant,  4'b0000);
            chk({tag, "_portTX"}, bus.portTX, 1'b1);
            chk({tag, "_busy"},   bus.busy,   1'b0);
            tick();
        end
    endtask

    // Waits for the next grant, then checks the whole 10-cell frame cycle by cycle.
    task automatic check_frame(string tag, logic [3:0] mid, logic [3:0] late, int gap);
        int         w;
        logic [7:0] b;
        logic [9:0] bits;
        logic [3:0] eg;
        bit         found;
        w = exp_w_q.pop_front();
        b = exp_b_q.pop_front();
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (bus.grant != 4'b0000) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        total++;
        assert (found) else begin
            bad++;
            $error("FAIL %s_grant_timeout observed=none expected=grant%0d", tag, w);
        end
        if (!found) return;
        if (gap != 0) chk({tag, "_gap"}, cyc_cnt - last_grant_cyc, gap);
        last_grant_cyc = cyc_cnt;
        chk({tag, "_owner"}, bus.owner, w);
        bits = {1'b1, b, 1'b0};
        for (int c = 0; c < 100; c++) begin
            eg = (c == 0) ? 4'(4'b0001 << w) : 4'b0000;
            chk({tag, "_grant"},  bus.grant,  eg);
            chk({tag, "_portTX"}, bus.portTX, bits[c / 10]);
            chk({tag, "_busy"},   bus.busy,   1'b1);
            if (c == 30) bus.req = mid;
            if (c == 85) bus.req = late;
            tick();
        end
        chk({tag, "_end_busy"},   bus.busy,   1'b0);
        chk({tag, "_end_portTX"}, bus.portTX, 1'b1);
    endtask

    initial begin
        bit found;
        bus.req     = 4'b0000;
        bus.reqData = 32'h0;

        // Reset held for three cycles, then idle.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_portTX", bus.portTX, 1'b1);
            chk("rst_busy",   bus.busy,   1'b0);
            chk("rst_grant",  bus.grant,  4'b0000);
            chk("rst_owner",  bus.owner,  2'd3);
        end
        rst_n = 1'b1;
        idle_check("post_rst", 5);
        chk("post_rst_owner", bus.owner, 2'd3);

        // Single request, byte A5.
        set_byte(0, 8'hA5);
        bus.req = 4'b0001;
        push(0, 8'hA5);
        check_frame("single", 4'b0000, 4'b0000, 0);
        idle_check("single_idle", 20);

        // Reset at clock 45 of a frame.
        bus.req = 4'b0001;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.grant != 4'b0000) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        total++;
        assert (found) else begin
            bad++;
            $error("FAIL abort_grant_timeout observed=none expected=grant0");
        end
        chk("abort_grant", bus.grant, 4'b0001);
        for (int i = 0; i < 44; i++) tick();
        rst_n = 1'b0;
        tick();
        chk("abort_portTX", bus.portTX, 1'b1);
        chk("abort_busy",   bus.busy,   1'b0);
        chk("abort_grant0", bus.grant,  4'b0000);
        chk("abort_owner",  bus.owner,  2'd3);
        tick();
        chk("abort_grant1", bus.grant,  4'b0000);
        rst_n = 1'b1;
        push(0, 8'hA5);
        check_frame("retry", 4'b0000, 4'b0000, 0);

        // All four requesting from a fresh pointer.
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        set_byte(0, 8'h00);
        set_byte(1, 8'hFF);
        set_byte(2, 8'h55);
        set_byte(3, 8'h0F);
        bus.req = 4'b1111;
        push(0, 8'h00); push(1, 8'hFF); push(2, 8'h55); push(3, 8'h0F); push(0, 8'h00);
        check_frame("rr0", 4'b1111, 4'b1111, 0);
        check_frame("rr1", 4'b1111, 4'b1111, 101);
        check_frame("rr2", 4'b1111, 4'b1111, 101);
        check_frame("rr3", 4'b1111, 4'b1111, 101);
        check_frame("rr4", 4'b0000, 4'b0000, 101);
        idle_check("rr_idle", 5);

        // Requester 1 pulses during a frame and drops before the stop bit.
        bus.req = 4'b0100;
        push(2, 8'h55); push(2, 8'h55);
        check_frame("pulse_a", 4'b0110, 4'b0100, 0);
        check_frame("pulse_b", 4'b0000, 4'b0000, 101);
        idle_check("pulse_idle", 5);

        // Pointer wraps from 3 back to 0.
        bus.req = 4'b1000;
        push(3, 8'h0F);
        check_frame("wrap_pre", 4'b0000, 4'b0000, 0);
        bus.req = 4'b1001;
        push(0, 8'h00); push(3, 8'h0F);
        check_frame("wrap_0", 4'b1000, 4'b1000, 0);
        check_frame("wrap_3", 4'b0000, 4'b0000, 101);
        idle_check("final_idle", 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic set_byte(int i, logic [7:0] b);
        bus.reqData[8*i +: 8] = b;
    endtask
endmodule
